// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter: default data width and the
// read-owner encoding that tags which port a pending read response belongs to.
package dmem_arbiter_pkg;

  // Core data/address width (mirrors XLEN in core_general.vh)
  localparam int unsigned CORE_XLEN = 32;

  // Width of the host starvation counter; large enough for STARVE_MAX up to 255
  localparam int unsigned STARVE_W = 8;

  // Owner of the read issued in the previous cycle
  typedef enum logic [1:0] {
    RD_OWNER_NONE = 2'b00,
    RD_OWNER_CORE = 2'b01,
    RD_OWNER_HOST = 2'b10
  } rd_owner_e;

  // Owner of the read response due next cycle, given this cycle's grants
  function automatic rd_owner_e rd_owner_next(input logic gnt_c, input logic c_we,
                                              input logic gnt_h, input logic h_we);
    rd_owner_e owner;
    owner = RD_OWNER_NONE;
    if (gnt_c && !c_we) begin
      owner = RD_OWNER_CORE;
    end else if (gnt_h && !h_we) begin
      owner = RD_OWNER_HOST;
    end
    return owner;
  endfunction

endpackage

// File: rtl/dmem_arbiter_starve.sv
// Host starvation tracker for dmem_arbiter: counts consecutive cycles the host
// has waited while the core was served and forces a host turn once the wait
// reaches STARVE_MAX.
module dmem_arb_starve
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic c_req,
  input  logic h_req,
  output logic host_turn
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_cnt;
  logic                at_limit;

  // Host wins when the core is idle or the host has waited long enough
  always_comb begin
    at_limit  = (starve_cnt == STARVE_LIM);
    host_turn = h_req & (~c_req | at_limit);
  end

  // Wait counter: a waiting host with no turn implies the core was granted,
  // so that condition alone advances the count (saturating at the limit)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!h_req || host_turn) begin
      starve_cnt <= '0;
    end else if (!at_limit) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the core data port
// (port 0, priority) and the host/debug port (port 1) with bounded host
// starvation. One access per cycle, read data returned one cycle after grant.
// Optional build macro DMEM_ARB_PERF_EN adds grant/stall performance counters.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned XLEN       = CORE_XLEN,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  // core port
  input  logic            c_req,
  input  logic            c_we,
  input  logic [XLEN-1:0] c_addr,
  input  logic [XLEN-1:0] c_wdata,
  output logic            c_gnt,
  output logic            c_rvalid,
  output logic [XLEN-1:0] c_rdata,
  // host port
  input  logic            h_req,
  input  logic            h_we,
  input  logic [XLEN-1:0] h_addr,
  input  logic [XLEN-1:0] h_wdata,
  output logic            h_gnt,
  output logic            h_rvalid,
  output logic [XLEN-1:0] h_rdata,
  // RAM port
  output logic [XLEN-1:0] m_addr,
  output logic [XLEN-1:0] m_wdata,
  output logic            m_we,
  output logic            m_re,
  input  logic [XLEN-1:0] m_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]     perf_c_gnt,
  output logic [31:0]     perf_h_gnt,
  output logic [31:0]     perf_h_stall
`endif
);

  logic            host_turn;
  logic            gnt_c;
  logic            gnt_h;
  rd_owner_e       rd_owner;
  logic [XLEN-1:0] c_rdata_q;
  logic [XLEN-1:0] h_rdata_q;

  dmem_arb_starve #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .rst_n     (rst_n),
    .c_req     (c_req),
    .h_req     (h_req),
    .host_turn (host_turn)
  );

  // Grant decision; qualified by rst_n so nothing is granted while in reset
  always_comb begin
    gnt_h = rst_n & host_turn;
    gnt_c = rst_n & c_req & ~host_turn;
  end

  assign c_gnt = gnt_c;
  assign h_gnt = gnt_h;

  // RAM request mux from the granted port; idle strobes when nothing granted
  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    m_we    = 1'b0;
    m_re    = 1'b0;
    if (gnt_h) begin
      m_addr  = h_addr;
      m_wdata = h_wdata;
      m_we    = h_we;
      m_re    = ~h_we;
    end else if (gnt_c) begin
      m_addr  = c_addr;
      m_wdata = c_wdata;
      m_we    = c_we;
      m_re    = ~c_we;
    end
  end

  // Read owner: tags the response arriving from the RAM next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_owner <= RD_OWNER_NONE;
    end else begin
      rd_owner <= rd_owner_next(gnt_c, c_we, gnt_h, h_we);
    end
  end

  assign c_rvalid = (rd_owner == RD_OWNER_CORE);
  assign h_rvalid = (rd_owner == RD_OWNER_HOST);

  // Hold registers keep each port's last returned word while it is not the owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_rdata_q <= '0;
      h_rdata_q <= '0;
    end else begin
      if (c_rvalid) begin
        c_rdata_q <= m_rdata;
      end
      if (h_rvalid) begin
        h_rdata_q <= m_rdata;
      end
    end
  end

  // RAM data passes straight through in the owner's valid cycle
  assign c_rdata = c_rvalid ? m_rdata : c_rdata_q;
  assign h_rdata = h_rvalid ? m_rdata : h_rdata_q;

`ifdef DMEM_ARB_PERF_EN
  // Performance counters: grants per port and host wait cycles, wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_c_gnt   <= '0;
      perf_h_gnt   <= '0;
      perf_h_stall <= '0;
    end else begin
      if (gnt_c) begin
        perf_c_gnt <= perf_c_gnt + 32'd1;
      end
      if (gnt_h) begin
        perf_h_gnt <= perf_h_gnt + 32'd1;
      end
      if (h_req && !gnt_h) begin
        perf_h_stall <= perf_h_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// traffic, checked against a behavioural model (shadow memory, host wait
// count) with a response scoreboard consumed by a separate monitor process.
module tb_dmem_arbiter;

  localparam int XLEN       = 32;
  localparam int STARVE_MAX = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            c_req = 1'b0, c_we = 1'b0;
  logic [XLEN-1:0] c_addr = '0, c_wdata = '0;
  logic            c_gnt, c_rvalid;
  logic [XLEN-1:0] c_rdata;
  logic            h_req = 1'b0, h_we = 1'b0;
  logic [XLEN-1:0] h_addr = '0, h_wdata = '0;
  logic            h_gnt, h_rvalid;
  logic [XLEN-1:0] h_rdata;
  logic [XLEN-1:0] m_addr, m_wdata;
  logic            m_we, m_re;
  logic [XLEN-1:0] m_rdata = '0;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0]     perf_c_gnt, perf_h_gnt, perf_h_stall;
`endif

  dmem_arbiter #(
    .XLEN       (XLEN),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .c_req    (c_req),
    .c_we     (c_we),
    .c_addr   (c_addr),
    .c_wdata  (c_wdata),
    .c_gnt    (c_gnt),
    .c_rvalid (c_rvalid),
    .c_rdata  (c_rdata),
    .h_req    (h_req),
    .h_we     (h_we),
    .h_addr   (h_addr),
    .h_wdata  (h_wdata),
    .h_gnt    (h_gnt),
    .h_rvalid (h_rvalid),
    .h_rdata  (h_rdata),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_we     (m_we),
    .m_re     (m_re),
    .m_rdata  (m_rdata)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_c_gnt   (perf_c_gnt),
    .perf_h_gnt   (perf_h_gnt),
    .perf_h_stall (perf_h_stall)
`endif
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : (32'h3C00_0000 ^ (i * 32'h0101_0107));
  endfunction

  // RAM environment: 64 words, synchronous write, 1-cycle read
  logic [31:0] ram [0:63];
  initial begin
    for (int i = 0; i < 64; i++) ram[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (m_we) ram[m_addr[7:2]] <= m_wdata;
      if (m_re) m_rdata <= ram[m_addr[7:2]];
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  logic [31:0] shadow [0:63];
  rsp_t        cq[$];
  rsp_t        hq[$];
  logic [31:0] c_last = '0, h_last = '0;
  int          hwait = 0;
  int          pc = 0, ph = 0, ps = 0;
  logic        last_ec = 1'b0, last_eh = 1'b0;
  logic        dut_cg = 1'b0, dut_hg = 1'b0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Called at the negative edge: predict this cycle's grant and RAM access
  task automatic check_cycle();
    logic eh, ec;
    eh = h_req && (!c_req || hwait == STARVE_MAX);
    ec = c_req && !eh;
    dut_cg = c_gnt;
    dut_hg = h_gnt;
    chk("c_gnt", c_gnt, ec);
    chk("h_gnt", h_gnt, eh);
    chk("m_we", m_we, (ec && c_we) || (eh && h_we));
    chk("m_re", m_re, (ec && !c_we) || (eh && !h_we));
    if (ec) begin
      chk("m_addr_c", m_addr, c_addr);
      if (c_we) begin
        chk("m_wdata_c", m_wdata, c_wdata);
        shadow[c_addr[7:2]] = c_wdata;
      end else begin
        cq.push_back('{cycle + 1, shadow[c_addr[7:2]]});
      end
    end
    if (eh) begin
      chk("m_addr_h", m_addr, h_addr);
      if (h_we) begin
        chk("m_wdata_h", m_wdata, h_wdata);
        shadow[h_addr[7:2]] = h_wdata;
      end else begin
        hq.push_back('{cycle + 1, shadow[h_addr[7:2]]});
      end
    end
    if (!h_req || eh) hwait = 0;
    else if (hwait < STARVE_MAX) hwait++;
    if (ec) pc++;
    if (eh) ph++;
    if (h_req && !eh) ps++;
    last_ec = ec;
    last_eh = eh;
  endtask

  // Monitor: pops expected read responses when the DUT presents rvalid
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (c_rvalid) begin
          if (cq.size() == 0) chk("c_rvalid_unexpected", c_rvalid, 1'b0);
          else begin
            r = cq.pop_front();
            chk("c_rvalid_cycle", cycle, r.due);
            chk("c_rdata", c_rdata, r.data);
            c_last = r.data;
          end
        end else begin
          if (cq.size() > 0 && cq[0].due <= cycle) begin
            chk("c_rvalid_missing", c_rvalid, 1'b1);
            void'(cq.pop_front());
          end
          chk("c_rdata_hold", c_rdata, c_last);
        end
        if (h_rvalid) begin
          if (hq.size() == 0) chk("h_rvalid_unexpected", h_rvalid, 1'b0);
          else begin
            r = hq.pop_front();
            chk("h_rvalid_cycle", cycle, r.due);
            chk("h_rdata", h_rdata, r.data);
            h_last = r.data;
          end
        end else begin
          if (hq.size() > 0 && hq[0].due <= cycle) begin
            chk("h_rvalid_missing", h_rvalid, 1'b1);
            void'(hq.pop_front());
          end
          chk("h_rdata_hold", h_rdata, h_last);
        end
      end
    end
  end

  task automatic drive_c(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    c_req = req; c_we = we; c_addr = addr; c_wdata = wdata;
  endtask

  task automatic drive_h(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    h_req = req; h_we = we; h_addr = addr; h_wdata = wdata;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    cq.delete();
    hq.delete();
    c_last = '0; h_last = '0;
    hwait = 0;
    pc = 0; ph = 0; ps = 0;
  endtask

  task automatic check_perf(input string tag);
`ifdef DMEM_ARB_PERF_EN
    chk({tag, "_perf_c_gnt"}, perf_c_gnt, pc);
    chk({tag, "_perf_h_gnt"}, perf_h_gnt, ph);
    chk({tag, "_perf_h_stall"}, perf_h_stall, ps);
`else
    if (tag.len() == 0) $display("note: empty perf tag");
`endif
  endtask

  initial begin
    int run;
    logic c_pend, h_pend;
    for (int i = 0; i < 64; i++) shadow[i] = init_word(i);

    // Reset held with both ports requesting: nothing may be granted
    drive_c(1'b1, 1'b0, 32'h10, '0);
    drive_h(1'b1, 1'b1, 32'h20, 32'h55);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_c_gnt", c_gnt, 1'b0);
      chk("rst_h_gnt", h_gnt, 1'b0);
      chk("rst_m_we", m_we, 1'b0);
      chk("rst_m_re", m_re, 1'b0);
      chk("rst_c_rvalid", c_rvalid, 1'b0);
      chk("rst_h_rvalid", h_rvalid, 1'b0);
    end
    check_perf("rst");

    // Core-only read of 0x10 (RAM holds DEADBEEF)
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    drive_c(1'b1, 1'b0, 32'h10, '0);
    drive_h(1'b0, 1'b0, '0, '0);
    tick();
    drive_c(1'b0, 1'b0, '0, '0);
    tick();
    chk("core_read_deadbeef", c_last, 32'hDEADBEEF);

    // Contention: core and host held; host must win after STARVE_MAX core grants
    drive_c(1'b1, 1'b0, 32'h0, '0);
    drive_h(1'b1, 1'b0, 32'h4, '0);
    run = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dut_hg) break;
      if (dut_cg) run++;
    end
    chk("starve_core_run", run, STARVE_MAX);
    chk("starve_host_won", dut_hg, 1'b1);
    drive_h(1'b0, 1'b0, '0, '0);
    tick();
    chk("core_resumes", dut_cg, 1'b1);
    drive_c(1'b0, 1'b0, '0, '0);
    tick();

    // Host write then core read of same address on the next cycle
    drive_h(1'b1, 1'b1, 32'h40, 32'h0000_00A5);
    tick();
    drive_h(1'b0, 1'b0, '0, '0);
    drive_c(1'b1, 1'b0, 32'h40, '0);
    tick();
    drive_c(1'b0, 1'b0, '0, '0);
    tick();
    chk("raw_core_read", c_last, 32'h0000_00A5);

    // Back-to-back alternating reads
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        drive_c(1'b1, 1'b0, 32'h0, '0);
        drive_h(1'b0, 1'b0, '0, '0);
      end else begin
        drive_c(1'b0, 1'b0, '0, '0);
        drive_h(1'b1, 1'b0, 32'h4, '0);
      end
      tick();
    end
    drive_c(1'b0, 1'b0, '0, '0);
    drive_h(1'b0, 1'b0, '0, '0);
    tick();

    // Random traffic with hold-until-grant protocol and occasional request drops
    for (int i = 0; i < 600; i++) begin
      c_pend = c_req && !last_ec;
      h_pend = h_req && !last_eh;
      if (!c_pend || $urandom_range(0, 15) == 0)
        drive_c($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 63)) << 2, $urandom);
      if (!h_pend || $urandom_range(0, 15) == 0)
        drive_h($urandom_range(0, 1) != 0, 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 63)) << 2, $urandom);
      tick();
    end
    drive_c(1'b0, 1'b0, '0, '0);
    drive_h(1'b0, 1'b0, '0, '0);
    tick();
    tick();
    check_perf("rand");

    // Reset asserted in a core read grant cycle: the read must be discarded
    drive_c(1'b1, 1'b0, 32'h10, '0);
    @(negedge clk);
    chk("pre_rst_c_gnt", c_gnt, 1'b1);
    #1;
    rst_n = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("in_rst_c_gnt", c_gnt, 1'b0);
    chk("in_rst_m_re", m_re, 1'b0);
    @(posedge clk); #1;
    drive_c(1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
    mon_en = 1'b1;
    check_perf("post_rst");
    for (int i = 0; i < 3; i++) tick();
    chk("post_rst_c_rvalid", c_rvalid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
